sram_pattern_tester: RTL

Parametrised self-checking traffic engine for the external asynchronous SRAM port. It generalises the fixed 16-bit, two-byte-lane stimulus process into configurable address width, data width, byte-lane count, access wait states and data pattern. On `start` it runs a write sweep over `DEPTH` words, then a read-back sweep, and compares each read word against the regenerated pattern. It sits between the system clock/reset generators and the SRAM pins, and reports pass/fail, error count and first failing address.

---
 rtl/sram_tester_pkg.sv | 35 +++
 rtl/sram_access_timer.sv | 34 +++
 rtl/sram_pattern_tester.sv | 238 +++++++++++++++++++++++
 3 files changed

// File: rtl/sram_tester_pkg.sv
// Shared types for the SRAM pattern tester: FSM states, pattern modes and the
// pattern generator used by both the write sweep and the read-back compare.
package sram_tester_pkg;

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_WR_SETUP  = 3'd1,
        ST_WR_STROBE = 3'd2,
        ST_WR_HOLD   = 3'd3,
        ST_RD_SETUP  = 3'd4,
        ST_RD_STROBE = 3'd5,
        ST_RD_HOLD   = 3'd6,
        ST_FINISH    = 3'd7
    } state_e;

    localparam logic [1:0] MODE_INDEX   = 2'd0;
    localparam logic [1:0] MODE_INVERT  = 2'd1;
    localparam logic [1:0] MODE_WALK1   = 2'd2;
    localparam logic [1:0] MODE_CHECKER = 2'd3;

    // Computed 64 bits wide; callers truncate to their data width (up to 64).
    function automatic logic [63:0] pat(input logic [1:0] mode, input logic [63:0] idx,
                                        input int width);
        logic [63:0] v_pat;
        case (mode)
            MODE_INDEX:   v_pat = idx;
            MODE_INVERT:  v_pat = ~idx;
            MODE_WALK1:   v_pat = 64'd1 << (idx % 64'(width));
            MODE_CHECKER: v_pat = idx[0] ? {32{2'b10}} : {32{2'b01}};
            default:      v_pat = 64'd0;
        endcase
        return v_pat;
    endfunction

endpackage

// File: rtl/sram_access_timer.sv
// Phase counter for one SRAM access: SETUP (1), STROBE (WAIT_CYCLES), HOLD (1).
// Shared by the write and read sweeps.
module sram_access_timer #(
    parameter int WAIT_CYCLES = 1
) (
    input  logic i_clk,
    input  logic i_rst,
    input  logic i_run,
    output logic o_strobe_active,
    output logic o_sample_now,
    output logic o_access_end
);
    localparam int CW = $clog2(WAIT_CYCLES + 2);

    logic [CW-1:0] r_cnt;

    // Phase count: 0 = setup, 1..WAIT_CYCLES = strobe, WAIT_CYCLES+1 = hold.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_cnt <= '0;
        end else if (!i_run || o_access_end) begin
            r_cnt <= '0;
        end else begin
            r_cnt <= r_cnt + CW'(1);
        end
    end

    always_comb begin
        o_strobe_active = (r_cnt != '0) && (r_cnt <= CW'(WAIT_CYCLES));
        o_sample_now    = (r_cnt == CW'(WAIT_CYCLES));
        o_access_end    = (r_cnt == CW'(WAIT_CYCLES + 1));
    end

endmodule

// File: rtl/sram_pattern_tester.sv
// SRAM traffic engine: write sweep, read-back sweep, compare against pattern.
// Pin registers are loaded from the current state, so pins lag the FSM by one cycle.
module sram_pattern_tester
    import sram_tester_pkg::*;
#(
    parameter int ADDR_WIDTH  = 16,
    parameter int DATA_WIDTH  = 16,
    parameter int DEPTH       = 2 ** ADDR_WIDTH,
    parameter int WAIT_CYCLES = 1,
    parameter int ERR_WIDTH   = 16,
    localparam int LANES      = DATA_WIDTH / 8
) (
    input  logic                  PCLK,
    input  logic                  SYSRESET,
    input  logic                  start,
    input  logic                  abort,
    input  logic [1:0]            mode,
    input  logic [DATA_WIDTH-1:0] io_data_read,
    output logic [ADDR_WIDTH-1:0] io_address,
    output logic [DATA_WIDTH-1:0] io_data_write,
    output logic                  io_data_writeEnable,
    output logic                  io_ce,
    output logic                  io_we,
    output logic                  io_oe,
    output logic [LANES-1:0]      io_be,
    output logic                  busy,
    output logic                  done,
    output logic                  pass,
    output logic [ERR_WIDTH-1:0]  error_count,
    output logic [ADDR_WIDTH-1:0] first_fail_addr
);
    state_e                r_state;
    state_e                w_next_state;
    logic [ADDR_WIDTH-1:0] r_idx;
    logic [ADDR_WIDTH-1:0] w_next_idx;
    logic [1:0]            r_mode;
    logic                  r_armed;
    logic                  w_accept, w_abort, w_wr_phase, w_rd_phase, w_in_access;
    logic                  w_last_idx, w_timer_run;
    logic                  w_strobe_active, w_sample_now, w_access_end;
    logic                  r_ce_n, r_we_n, r_oe_n, r_wen, r_busy, r_done, r_pass;
    logic [LANES-1:0]      r_be_n;
    logic [ADDR_WIDTH-1:0] r_addr, r_cmp_addr, r_ffa;
    logic [DATA_WIDTH-1:0] r_wdata, r_rd_data, w_pat_idx, w_pat_cmp;
    logic [ERR_WIDTH-1:0]  r_err, w_err_next;
    logic                  r_sample_d, r_cmp_valid, w_mismatch;

    always_comb begin
        w_wr_phase  = (r_state == ST_WR_SETUP) || (r_state == ST_WR_STROBE) ||
                      (r_state == ST_WR_HOLD);
        w_rd_phase  = (r_state == ST_RD_SETUP) || (r_state == ST_RD_STROBE) ||
                      (r_state == ST_RD_HOLD);
        w_in_access = w_wr_phase || w_rd_phase;
        w_abort     = abort && (r_state != ST_IDLE);
        // r_armed blocks a start sampled on the first edge after reset release.
        w_accept    = (r_state == ST_IDLE) && start && !abort && r_armed;
        w_last_idx  = (r_idx == ADDR_WIDTH'(DEPTH - 1));
        w_timer_run = w_in_access && !w_abort;
        w_pat_idx   = DATA_WIDTH'(pat(r_mode, 64'(r_idx), DATA_WIDTH));
        w_pat_cmp   = DATA_WIDTH'(pat(r_mode, 64'(r_cmp_addr), DATA_WIDTH));
    end

    sram_access_timer #(
        .WAIT_CYCLES(WAIT_CYCLES)
    ) u_timer (
        .i_clk          (PCLK),
        .i_rst          (SYSRESET),
        .i_run          (w_timer_run),
        .o_strobe_active(w_strobe_active),
        .o_sample_now   (w_sample_now),
        .o_access_end   (w_access_end)
    );

    // Next state and index; the index is compared before increment so it never wraps.
    always_comb begin
        w_next_state = r_state;
        w_next_idx   = r_idx;
        if (w_abort) begin
            w_next_state = ST_IDLE;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (w_accept) begin
                        w_next_state = ST_WR_SETUP;
                        w_next_idx   = '0;
                    end else begin
                        w_next_state = ST_IDLE;
                    end
                end
                ST_WR_SETUP:  w_next_state = ST_WR_STROBE;
                ST_WR_STROBE: w_next_state = w_sample_now ? ST_WR_HOLD : ST_WR_STROBE;
                ST_WR_HOLD: begin
                    if (!w_access_end) begin
                        w_next_state = ST_WR_HOLD;
                    end else if (w_last_idx) begin
                        w_next_state = ST_RD_SETUP;
                        w_next_idx   = '0;
                    end else begin
                        w_next_state = ST_WR_SETUP;
                        w_next_idx   = r_idx + ADDR_WIDTH'(1);
                    end
                end
                ST_RD_SETUP:  w_next_state = ST_RD_STROBE;
                ST_RD_STROBE: w_next_state = w_sample_now ? ST_RD_HOLD : ST_RD_STROBE;
                ST_RD_HOLD: begin
                    if (!w_access_end) begin
                        w_next_state = ST_RD_HOLD;
                    end else if (w_last_idx) begin
                        w_next_state = ST_FINISH;
                    end else begin
                        w_next_state = ST_RD_SETUP;
                        w_next_idx   = r_idx + ADDR_WIDTH'(1);
                    end
                end
                ST_FINISH: w_next_state = ST_IDLE;
                default:   w_next_state = ST_IDLE;
            endcase
        end
    end

    // State, index, latched mode and post-reset arming flag.
    always_ff @(posedge PCLK or posedge SYSRESET) begin
        if (SYSRESET) begin
            r_state <= ST_IDLE;
            r_idx   <= '0;
            r_mode  <= 2'd0;
            r_armed <= 1'b0;
        end else begin
            r_state <= w_next_state;
            r_idx   <= w_next_idx;
            r_armed <= 1'b1;
            if (w_accept) begin
                r_mode <= mode;
            end
        end
    end

    // Pin registers; an abort returns every strobe to idle on the next edge.
    always_ff @(posedge PCLK or posedge SYSRESET) begin
        if (SYSRESET) begin
            r_ce_n  <= 1'b1;
            r_we_n  <= 1'b1;
            r_oe_n  <= 1'b1;
            r_be_n  <= '1;
            r_wen   <= 1'b0;
            r_addr  <= '0;
            r_wdata <= '0;
            r_busy  <= 1'b0;
        end else if (w_abort) begin
            r_ce_n  <= 1'b1;
            r_we_n  <= 1'b1;
            r_oe_n  <= 1'b1;
            r_be_n  <= '1;
            r_wen   <= 1'b0;
            r_busy  <= 1'b0;
        end else begin
            r_ce_n  <= !w_in_access;
            r_we_n  <= !(w_strobe_active && w_wr_phase);
            r_oe_n  <= !(w_strobe_active && w_rd_phase);
            r_be_n  <= w_in_access ? '0 : '1;
            r_wen   <= w_wr_phase;
            r_busy  <= w_in_access;
            if (w_in_access) begin
                r_addr <= r_idx;
            end
            if (w_wr_phase) begin
                r_wdata <= w_pat_idx;
            end
        end
    end

    // Capture read data at the end of the last pin-visible strobe cycle.
    always_ff @(posedge PCLK or posedge SYSRESET) begin
        if (SYSRESET) begin
            r_sample_d  <= 1'b0;
            r_cmp_valid <= 1'b0;
            r_rd_data   <= '0;
            r_cmp_addr  <= '0;
        end else if (w_abort) begin
            r_sample_d  <= 1'b0;
            r_cmp_valid <= 1'b0;
        end else begin
            r_sample_d  <= w_sample_now && w_rd_phase;
            r_cmp_valid <= r_sample_d;
            if (r_sample_d) begin
                r_rd_data  <= io_data_read;
                r_cmp_addr <= r_addr;
            end
        end
    end

    always_comb begin
        w_mismatch = r_cmp_valid && (r_rd_data != w_pat_cmp);
        if (w_mismatch && (r_err != {ERR_WIDTH{1'b1}})) begin
            w_err_next = r_err + ERR_WIDTH'(1);
        end else begin
            w_err_next = r_err;
        end
    end

    // Result registers; the last compare lands on the same edge as done.
    always_ff @(posedge PCLK or posedge SYSRESET) begin
        if (SYSRESET) begin
            r_done <= 1'b0;
            r_pass <= 1'b0;
            r_err  <= '0;
            r_ffa  <= '0;
        end else if (w_accept) begin
            r_done <= 1'b0;
            r_pass <= 1'b0;
            r_err  <= '0;
            r_ffa  <= '0;
        end else if (!w_abort) begin
            r_err <= w_err_next;
            if (w_mismatch && (r_err == '0)) begin
                r_ffa <= r_cmp_addr;
            end
            if (r_state == ST_FINISH) begin
                r_done <= 1'b1;
                r_pass <= (w_err_next == '0);
            end
        end
    end

    assign io_address          = r_addr;
    assign io_data_write       = r_wdata;
    assign io_data_writeEnable = r_wen;
    assign io_ce               = r_ce_n;
    assign io_we               = r_we_n;
    assign io_oe               = r_oe_n;
    assign io_be               = r_be_n;
    assign busy                = r_busy;
    assign done                = r_done;
    assign pass                = r_pass;
    assign error_count         = r_err;
    assign first_fail_addr     = r_ffa;

endmodule
